// File: rtl/stream_demux8_if.sv
// Stream demultiplexer bus: one valid/ready input stream, eight registered
// output channels with independent valid/ready, and an accept counter.
interface stream_demux8_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   in_data;
    logic [2:0]          in_sel;
    logic                in_bcast;
    logic                in_valid;
    logic                in_ready;
    logic [8*DATA_W-1:0] out_data;
    logic [7:0]          out_valid;
    logic [7:0]          out_ready;
    logic [15:0]         accept_cnt;

    // Producer / consumer side (drives the input stream, takes the channels)
    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, accept_cnt
    );

    // Demultiplexer side
    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, accept_cnt
    );
endinterface

// File: rtl/stream_demux8.sv
// 1-to-8 registered stream demultiplexer with broadcast. Each channel owns a
// one-entry output register, so a stalled channel only blocks words sent to it.
module stream_demux8 #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux8_if.slave bus
);
    logic [DATA_W-1:0] data_q [8];
    logic [DATA_W-1:0] data_d [8];
    logic [7:0]        valid_q;
    logic [7:0]        valid_d;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic [7:0]        slot_free;
    logic              ready_run;
    logic              accept;

    // A slot can take a word when empty or being drained this same cycle
    always_comb begin
        slot_free = ~valid_q | bus.out_ready;
        ready_run = bus.in_bcast ? (&slot_free) : slot_free[bus.in_sel];
        // While reset is held nothing is accepted; ready only shows for an idle unicast request
        bus.in_ready = rst_n ? ready_run : (~bus.in_valid & ~bus.in_bcast);
        accept       = rst_n & bus.in_valid & ready_run;
    end

    // Next-state: drain consumed slots, then load the accepted word on top
    always_comb begin
        valid_d = valid_q & ~bus.out_ready;
        for (int k = 0; k < 8; k++) begin
            data_d[k] = data_q[k];
        end
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 16'd1;
            if (bus.in_bcast) begin
                valid_d = 8'hFF;
                for (int k = 0; k < 8; k++) begin
                    data_d[k] = bus.in_data;
                end
            end else begin
                valid_d[bus.in_sel] = 1'b1;
                data_d[bus.in_sel]  = bus.in_data;
            end
        end
    end

    // Channel registers and accept counter, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 8'h00;
            cnt_q   <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Flatten the channel registers onto the output bus
    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < 8; k++) begin
            bus.out_data[k*DATA_W +: DATA_W] = data_q[k];
        end
        bus.out_valid  = valid_q;
        bus.accept_cnt = cnt_q;
    end
endmodule

// File: tb/tb_stream_demux8.sv
// Directed bench for stream_demux8: reset, unicast, back-to-back, blocked
// broadcast, channel isolation, ignored inputs and counter wrap.
module tb_stream_demux8;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [15:0] exp_cnt;

    stream_demux8_if #(.DATA_W(8)) bus ();

    stream_demux8 #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ch(input int k);
        return bus.out_data[k*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_bcast  = 1'b0;
        bus.in_sel    = 3'd0;
        bus.in_data   = 8'h00;
        bus.out_ready = 8'h00;
    endtask

    task automatic drain_all();
        idle_inputs();
        bus.out_ready = 8'hFF;
        step();
        bus.out_ready = 8'h00;
        checks++;
        if (bus.out_valid !== 8'h00) begin
            failures++;
            $display("FAIL drain_all out_valid got=%h exp=00", bus.out_valid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.accept_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_init valid=%h cnt=%h exp 00/0000", bus.out_valid, bus.accept_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_idle got=%b exp=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_valid got=%b exp=0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // fill slots 2 and 5
        bus.in_valid = 1'b1; bus.in_sel = 3'd2; bus.in_data = 8'h22;
        step();
        bus.in_sel = 3'd5; bus.in_data = 8'h55;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 8'h24 || bus.accept_cnt !== 16'd2 || ch(2) !== 8'h22 || ch(5) !== 8'h55) begin
            failures++;
            $display("FAIL reset_fill valid=%h cnt=%h d2=%h d5=%h exp 24/0002/22/55",
                     bus.out_valid, bus.accept_cnt, ch(2), ch(5));
        end
        // asynchronous reset, away from the clock edge
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.accept_cnt !== 16'd0 || bus.out_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_async valid=%h cnt=%h data=%h exp 00/0000/0",
                     bus.out_valid, bus.accept_cnt, bus.out_data);
        end
        // words offered during reset are not taken
        bus.in_valid = 1'b1; bus.in_sel = 3'd2; bus.in_data = 8'h99;
        step();
        checks++;
        if (bus.out_valid !== 8'h00 || bus.accept_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_no_accept valid=%h cnt=%h exp 00/0000", bus.out_valid, bus.accept_cnt);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) begin
            bus.in_sel = 3'(s);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_release_ready sel=%0d got=%b exp=1", s, bus.in_ready);
            end
        end
        exp_cnt = 16'd0;
        step();
    endtask

    task automatic test_unicast();
        idle_inputs();
        bus.in_sel = 3'd3; bus.in_data = 8'hA5; bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL uni_ready_empty got=%b exp=1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (bus.out_valid !== 8'h08 || ch(3) !== 8'hA5 || bus.accept_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL uni_out valid=%h d3=%h cnt=%h exp 08/A5/%h", bus.out_valid, ch(3), bus.accept_cnt, exp_cnt);
        end
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL uni_ready_sel3 got=%b exp=0", bus.in_ready);
        end
        bus.in_sel = 3'd4;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL uni_ready_sel4 got=%b exp=1", bus.in_ready);
        end
        // held word stays put while stalled
        step();
        checks++;
        if (bus.out_valid !== 8'h08 || ch(3) !== 8'hA5) begin
            failures++;
            $display("FAIL uni_hold valid=%h d3=%h exp 08/A5", bus.out_valid, ch(3));
        end
        bus.in_sel = 3'd3;
        bus.out_ready = 8'h08;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL uni_ready_draining got=%b exp=1", bus.in_ready);
        end
        step();
        bus.out_ready = 8'h00;
        checks++;
        if (bus.out_valid !== 8'h00 || ch(3) !== 8'hA5) begin
            failures++;
            $display("FAIL uni_drain valid=%h d3=%h exp 00/A5", bus.out_valid, ch(3));
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bus.out_ready = 8'h40;
        bus.in_sel = 3'd6;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.in_ready);
            end
            step();
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (bus.out_valid !== 8'h40 || ch(6) !== 8'h10 + 8'(i)) begin
                failures++;
                $display("FAIL b2b_data i=%0d valid=%h d6=%h exp 40/%h", i, bus.out_valid, ch(6), 8'h10 + 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 8'h00 || ch(6) !== 8'h12 || bus.accept_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL b2b_end valid=%h d6=%h cnt=%h exp 00/12/%h", bus.out_valid, ch(6), bus.accept_cnt, exp_cnt);
        end
        bus.out_ready = 8'h00;
    endtask

    task automatic test_bcast_blocked();
        idle_inputs();
        bus.in_sel = 3'd0; bus.in_data = 8'h01; bus.in_valid = 1'b1;
        step();
        exp_cnt = exp_cnt + 16'd1;
        bus.in_bcast = 1'b1; bus.in_data = 8'h3C; bus.in_sel = 3'd5;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bcast_blocked_ready got=%b exp=0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_valid !== 8'h01 || ch(0) !== 8'h01 || bus.accept_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL bcast_blocked_state valid=%h d0=%h cnt=%h exp 01/01/%h", bus.out_valid, ch(0), bus.accept_cnt, exp_cnt);
        end
        bus.out_ready = 8'h01;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bcast_unblocked_ready got=%b exp=1", bus.in_ready);
        end
        step();
        exp_cnt = exp_cnt + 16'd1;
        idle_inputs();
        checks++;
        if (bus.out_valid !== 8'hFF || bus.out_data !== {8{8'h3C}} || bus.accept_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL bcast_out valid=%h data=%h cnt=%h exp FF/3C..3C/%h", bus.out_valid, bus.out_data, bus.accept_cnt, exp_cnt);
        end
        drain_all();
    endtask

    task automatic test_isolation();
        idle_inputs();
        bus.in_sel = 3'd1; bus.in_data = 8'h77; bus.in_valid = 1'b1;
        step();
        exp_cnt = exp_cnt + 16'd1;
        bus.out_ready = 8'h80;
        bus.in_sel = 3'd7;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'h70 + 8'(i);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL iso_ready i=%0d got=%b exp=1", i, bus.in_ready);
            end
            step();
            exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (ch(7) !== 8'h70 + 8'(i) || ch(1) !== 8'h77 || bus.out_valid !== 8'h82) begin
                failures++;
                $display("FAIL iso_data i=%0d d7=%h d1=%h valid=%h exp %h/77/82", i, ch(7), ch(1), bus.out_valid, 8'h70 + 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.accept_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL iso_cnt got=%h exp=%h", bus.accept_cnt, exp_cnt);
        end
        drain_all();
    endtask

    task automatic test_ignored_inputs();
        idle_inputs();
        bus.out_ready = 8'h5A;
        bus.in_bcast = 1'b1; bus.in_data = 8'hEE; bus.in_sel = 3'd4;
        step();
        bus.in_bcast = 1'b0; bus.in_sel = 3'd2;
        step();
        checks++;
        if (bus.out_valid !== 8'h00 || bus.accept_cnt !== exp_cnt || ch(4) === 8'hEE) begin
            failures++;
            $display("FAIL ignored valid=%h cnt=%h d4=%h exp 00/%h/not EE", bus.out_valid, bus.accept_cnt, ch(4), exp_cnt);
        end
        bus.in_bcast = 1'b1;
        bus.out_ready = 8'h00;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ignored_bcast_ready_empty got=%b exp=1", bus.in_ready);
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        int n;
        idle_inputs();
        n = 65535 - int'(exp_cnt);
        bus.out_ready = 8'hFF;
        bus.in_sel = 3'd0;
        bus.in_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (bus.accept_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_pre got=%h exp=FFFF", bus.accept_cnt);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.accept_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero got=%h exp=0000", bus.accept_cnt);
        end
        step();
        checks++;
        if (bus.accept_cnt !== 16'h0000 || bus.out_valid !== 8'h00) begin
            failures++;
            $display("FAIL wrap_idle cnt=%h valid=%h exp 0000/00", bus.accept_cnt, bus.out_valid);
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;
        test_reset();
        test_unicast();
        test_back_to_back();
        test_bcast_blocked();
        test_isolation();
        test_ignored_inputs();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
